// File: rtl/condicionador_botoes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : condicionador_botoes                                             |
// | Brief   : Synchronises and debounces raw push-buttons and emits one pulse  |
// |           per accepted press, holding the captured button vector.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module condicionador_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic                jogada,
    output logic [N_BOTOES-1:0] jogada_codigo,
    output logic                multiplos,
    output logic [1:0]          db_estado
);

    localparam int            CW           = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] ULTIMO_CICLO = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        ARMADO       = 2'b00,
        PULSO        = 2'b01,
        ESPERA_SOLTA = 2'b10
    } estado_t;

    logic [N_BOTOES-1:0] meta;
    logic [N_BOTOES-1:0] sinc;
    logic [N_BOTOES-1:0] deb;
    logic [CW-1:0]       contador;
    estado_t             estado;
    estado_t             proximo;
    logic                captura;

    // Two-stage synchroniser; the raw buttons are fully asynchronous.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            sinc <= '0;
        end else begin
            meta <= botoes;
            sinc <= meta;
        end
    end

    // One counter for the whole vector: any return of sinc to deb restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb      <= '0;
            contador <= '0;
        end else if (sinc == deb) begin
            contador <= '0;
        end else if (contador == ULTIMO_CICLO) begin
            deb      <= sinc;
            contador <= '0;
        end else begin
            contador <= contador + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= ARMADO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        captura = 1'b0;
        case (estado)
            ARMADO: begin
                if (deb != '0) begin
                    if (habilita) begin
                        proximo = PULSO;
                        captura = 1'b1;
                    end else begin
                        // Press seen while not enabled is swallowed until release.
                        proximo = ESPERA_SOLTA;
                    end
                end
            end
            PULSO:        proximo = ESPERA_SOLTA;
            ESPERA_SOLTA: if (deb == '0) proximo = ARMADO;
            default:      proximo = ARMADO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogada_codigo <= '0;
            multiplos     <= 1'b0;
        end else if (captura) begin
            jogada_codigo <= deb;
            multiplos     <= ($countones(deb) > 1);
        end
    end

    assign jogada    = (estado == PULSO);
    assign db_estado = estado;

endmodule
`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_condicionador_botoes                                          |
// | Brief   : Directed and random stimulus against a behavioural button model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_condicionador_botoes;

    localparam int N = 4;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] botoes;
    logic         habilita;
    logic         jogada;
    logic [N-1:0] jogada_codigo;
    logic         multiplos;
    logic [1:0]   db_estado;

    int n_cmp = 0;
    int n_err = 0;

    condicionador_botoes #(
        .N_BOTOES       (N),
        .DEBOUNCE_CICLOS(D)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes       (botoes),
        .habilita     (habilita),
        .jogada       (jogada),
        .jogada_codigo(jogada_codigo),
        .multiplos    (multiplos),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // Behavioural model: raw value reaches the filter two edges late; the
    // filtered value adopts the synced value after D consecutive differing edges.
    logic [N-1:0] m_s1 = '0, m_sinc = '0, m_deb = '0, m_cod = '0;
    int           m_dif = 0;
    int           m_st = 0;   // 0 armed, 1 pulse, 2 waiting for release
    int           m_nst;
    logic         m_mult = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_sinc = '0; m_deb = '0; m_cod = '0;
            m_dif = 0; m_st = 0; m_mult = 1'b0;
        end else begin
            m_nst = m_st;
            if (m_st == 0 && m_deb != 0) begin
                if (habilita) begin
                    m_nst  = 1;
                    m_cod  = m_deb;
                    m_mult = ((m_deb & (m_deb - 1'b1)) != 0);
                end else begin
                    m_nst = 2;
                end
            end else if (m_st == 1) begin
                m_nst = 2;
            end else if (m_st == 2 && m_deb == 0) begin
                m_nst = 0;
            end
            m_st = m_nst;
            if (m_sinc != m_deb) begin
                m_dif++;
                if (m_dif == D) begin
                    m_deb = m_sinc;
                    m_dif = 0;
                end
            end else begin
                m_dif = 0;
            end
            m_sinc = m_s1;
            m_s1   = botoes;
        end
    end

    always @(negedge clock) begin
        verifica("m_jogada", 32'(jogada), 32'(m_st == 1));
        verifica("m_codigo", 32'(jogada_codigo), 32'(m_cod));
        verifica("m_multiplos", 32'(multiplos), 32'(m_mult));
        verifica("m_estado", 32'(db_estado), 32'(m_st));
    end

    task automatic ciclos(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Edge i=0 is the first rising edge after the call.
    task automatic mede(input int n, output int primeiro, output int total, output int est_or);
        primeiro = -1;
        total    = 0;
        est_or   = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            est_or |= int'(db_estado);
            if (jogada) begin
                total++;
                if (primeiro < 0) primeiro = i;
            end
        end
        @(posedge clock);
        #2;
    endtask

    task automatic checa_reset(input string tag);
        verifica({tag, "_jogada"}, 32'(jogada), 0);
        verifica({tag, "_codigo"}, 32'(jogada_codigo), 0);
        verifica({tag, "_multiplos"}, 32'(multiplos), 0);
        verifica({tag, "_estado"}, 32'(db_estado), 0);
    endtask

    int p, t, e, r;

    initial begin
        reset    = 1'b0;
        botoes   = '0;
        habilita = 1'b0;
        #1 reset = 1'b1;
        #1 checa_reset("rst0");
        ciclos(2);
        reset = 1'b0;

        // 1: single press, exact latency
        habilita = 1'b1;
        botoes   = 4'b0010;
        mede(20, p, t, e);
        verifica("s1_primeiro", p, 6);
        verifica("s1_total", t, 1);
        verifica("s1_codigo", 32'(jogada_codigo), 32'b0010);
        verifica("s1_multiplos", 32'(multiplos), 0);
        botoes = '0;
        ciclos(10);

        // 2: glitch shorter than the debounce window
        botoes = 4'b0100;
        ciclos(3);
        botoes = '0;
        mede(15, p, t, e);
        verifica("s2_total", t, 0);
        verifica("s2_estado", e, 0);

        // 3: two separate holds give two pulses
        botoes = 4'b0001;
        mede(15, p, t, e);
        verifica("s3a_total", t, 1);
        verifica("s3a_codigo", 32'(jogada_codigo), 32'b0001);
        botoes = '0;
        ciclos(10);
        botoes = 4'b1000;
        mede(15, p, t, e);
        verifica("s3b_total", t, 1);
        verifica("s3b_codigo", 32'(jogada_codigo), 32'b1000);
        botoes = '0;
        ciclos(10);

        // 4: press while disabled is swallowed until release
        habilita = 1'b0;
        botoes   = 4'b0010;
        ciclos(10);
        habilita = 1'b1;
        mede(10, p, t, e);
        verifica("s4_total", t, 0);
        verifica("s4_codigo", 32'(jogada_codigo), 32'b1000);
        botoes = '0;
        ciclos(10);
        botoes = 4'b0010;
        mede(15, p, t, e);
        verifica("s4b_total", t, 1);
        verifica("s4b_codigo", 32'(jogada_codigo), 32'b0010);
        botoes = '0;
        ciclos(10);

        // 5: simultaneous press, extra button ignored while waiting
        botoes = 4'b0011;
        mede(15, p, t, e);
        verifica("s5_total", t, 1);
        verifica("s5_codigo", 32'(jogada_codigo), 32'b0011);
        verifica("s5_multiplos", 32'(multiplos), 1);
        botoes = 4'b0111;
        mede(10, p, t, e);
        verifica("s5b_total", t, 0);
        verifica("s5b_codigo", 32'(jogada_codigo), 32'b0011);
        botoes = '0;
        ciclos(10);

        // 6: asynchronous reset during the pulse, then during debounce
        botoes = 4'b0011;
        ciclos(7);
        verifica("s6_em_pulso", 32'(jogada), 1);
        reset = 1'b1;
        #1 checa_reset("s6a");
        @(posedge clock);
        #2 reset = 1'b0;
        mede(12, p, t, e);
        verifica("s6a_primeiro", p, 6);
        verifica("s6a_total", t, 1);
        verifica("s6a_multiplos", 32'(multiplos), 1);
        botoes = '0;
        ciclos(10);
        botoes = 4'b0100;
        ciclos(3);
        reset = 1'b1;
        #1 checa_reset("s6b");
        @(posedge clock);
        #2 reset = 1'b0;
        mede(12, p, t, e);
        verifica("s6b_primeiro", p, 6);
        verifica("s6b_codigo", 32'(jogada_codigo), 32'b0100);
        botoes = '0;
        ciclos(10);

        // Random phase: the model checks every cycle
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      botoes = '0;
            else if (r < 8) botoes = N'(1 << $urandom_range(0, N - 1));
            else            botoes = N'($urandom);
            habilita = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                #1 reset = 1'b1;
                ciclos(1);
                reset = 1'b0;
            end
            ciclos($urandom_range(1, 9));
        end
        botoes = '0;
        ciclos(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
